wbus_xfer_sequencer: RTL and testbench
======================================

// Module: wbus_xfer_sequencer
// PURPOSE
//  Schedules register-to-register transfers over the shared write bus through the service gates.
//  - Generates the 12-step timepulse ring T01..T12 and splits it into four 3-pulse transfer slots.
//  - Arbitrates round-robin between NREQ requesters.
//  - Drives one active-low read gate, a mask of active-low write gates, and optional clear strobes.
//  - Sits between the control-pulse sources and the read/write/clear gate inputs of the service-gate logic.
// PARAMETERS
//  NREQ   4   number of transfer requesters
//  NREG   16  number of gated registers; register code width is $clog2(NREG)
// PORTS
//  clk          in   1            system clock; all state on rising edge
//  rst_         in   1            asynchronous, active-low reset
//  ena          in   1            timepulse advance enable; ring holds when 0
//  inhibit      in   1            suppresses new grants; a slot already in progress completes
//  req          in   NREQ         per-requester transfer request, level, held until ack
//  req_src      in   NREQ*CW      per-requester source register code (CW=$clog2(NREG))
//  req_dst      in   NREQ*NREG    per-requester destination one-hot/multi-hot write mask
//  req_clr      in   NREQ         1 = clear destinations in phase 0 before write
//  ack          out  NREQ         one-cycle grant pulse to winning requester
//  err          out  1            one-cycle pulse with ack when granted req_dst==0
//  tp           out  12           one-hot timepulse, bit0=T01
//  rg_          out  NREG         active-low read gates, at most one low
//  wg_          out  NREG         active-low write gates
//  cg           out  NREG         active-high clear gates
//  busy         out  1            a granted transfer occupies the current slot
//  grant_id     out  $clog2(NREQ) index of last granted requester
// BEHAVIOUR
//  Reset state (asynchronous): tp=12'h001; rg_/wg_ all 1; cg=0; ack=0; err=0; busy=0; grant_id=0.
//  Reset also clears all latched transfers and sets the round-robin pointer to 0.
//  Reset mid-slot releases all gates immediately, with no glitch-hold.
//  Timepulse ring:
//  - tp index n=0..11 advances by 1 per clk when ena=1 and wraps 11->0.
//  - slot=n/3, phase=n%3.
//  - When ena=0, the ring and all outputs hold, and no ack is issued.
//  Arbitration cycle is phase 2 (T03,T06,T09,T12) with ena=1 and inhibit=0.
//  - Winner: first requester with req=1 starting at the RR pointer.
//  - ack[winner]=1 for that cycle.
//  - req_src/req_dst/req_clr are latched; the pointer moves to winner+1 mod NREQ.
//  - No requester with req=1: pointer unchanged.
//  Execution, in the following slot:
//  - phase 0: cg=dst mask if clr latched, else 0.
//  - phase 1: rg_[src]=0 and wg_=~dst.
//  - phase 2: all gates released.
//  - busy=1 during phases 0-1 of an executing slot.
//  Latency: request seen at an arbitration cycle -> clear 1 cycle later -> read/write 2 cycles later.
//  A request arriving in phase 0/1 waits for the next phase 2.
//  dst==0: the grant still acks with err=1, the slot is consumed, and no gates are asserted.
//  src in dst is legal (rg_ and wg_ same bit both low).
//  A src code >= NREG is treated as dst==0 (err).
//  inhibit=1 at an arbitration cycle: no ack, next slot idle.
//  inhibit changing during execution does not affect the running slot.
//  Back-to-back: a grant in phase 2 of slot k executes in slot k+1 while the next arbitration occurs at the end of slot k+1.
//  T12->T01 wrap behaves like any other slot boundary.
//  Requester deasserting req before ack: the request is simply not considered; no error.
// STRUCTURE
//  Shared package wbus_pkg holds:
//  - register code constants (A=0,L=1,Q=2,EB=3,FB=4,Z=5,BB=6,G=7,B=8,S=9,Y=10);
//  - localparams TP_N=12, SLOT_LEN=3, PH_CLR=0, PH_XFER=1, PH_ARB=2;
//  - a typedef for the latched transfer record {src,dst,clr,err}.
//  Sub-module rr_arbiter (NREQ, combinational pick plus registered pointer) is instantiated once.
//  Timepulse ring, slot latch and gate decode stay in this module.
// TESTING
//  1. Reset: hold rst_=0 -> tp=12'h001, rg_=16'hFFFF, wg_=16'hFFFF, cg=0, ack=0; release -> tp walks 001,002,004..800,001.
//  2. Single transfer: req[0]=1, src=0(A), dst=16'h0004(Q), clr=1 at T03 ->
//     ack=4'b0001 at T03, cg=16'h0004 at T04, rg_=16'hFFFE and wg_=16'hFFFB at T05, all released at T06.
//  3. Contention: req=4'b0011 held -> acks 0001 at T03 then 0010 at T06; re-raise both at T09 -> winner 0 (pointer=2 wraps to 0).
//  4. Error: req[2] with dst=0 -> ack=4'b0100 and err=1 same cycle, no rg_/wg_/cg activity in next slot.
//  5. Inhibit: inhibit=1 over T01..T12 with req=4'b1111 -> no acks, gates stay idle, tp keeps cycling; drop inhibit -> grant at next arbitration.
//  6. Reset mid-transfer: assert rst_=0 while rg_/wg_ active at T05 -> gates go all-1 asynchronously; after release the first grant goes to requester 0.

Source files
------------

// File: rtl/wbus_pkg.sv
// Shared definitions for the write-bus transfer sequencer: register codes,
// timepulse/slot geometry and the latched transfer record.
package wbus_pkg;

    localparam int NREG_DEF = 16;
    localparam int CODE_W   = $clog2(NREG_DEF);

    localparam logic [CODE_W-1:0] REG_A  = CODE_W'(0);
    localparam logic [CODE_W-1:0] REG_L  = CODE_W'(1);
    localparam logic [CODE_W-1:0] REG_Q  = CODE_W'(2);
    localparam logic [CODE_W-1:0] REG_EB = CODE_W'(3);
    localparam logic [CODE_W-1:0] REG_FB = CODE_W'(4);
    localparam logic [CODE_W-1:0] REG_Z  = CODE_W'(5);
    localparam logic [CODE_W-1:0] REG_BB = CODE_W'(6);
    localparam logic [CODE_W-1:0] REG_G  = CODE_W'(7);
    localparam logic [CODE_W-1:0] REG_B  = CODE_W'(8);
    localparam logic [CODE_W-1:0] REG_S  = CODE_W'(9);
    localparam logic [CODE_W-1:0] REG_Y  = CODE_W'(10);

    localparam int TP_N     = 12;
    localparam int SLOT_LEN = 3;

    localparam logic [1:0] PH_CLR  = 2'd0;
    localparam logic [1:0] PH_XFER = 2'd1;
    localparam logic [1:0] PH_ARB  = 2'd2;

    // Record is sized for the default 16-register file.
    typedef struct packed {
        logic [CODE_W-1:0]   src;
        logic [NREG_DEF-1:0] dst;
        logic                clr;
        logic                err;
    } xfer_t;

    typedef enum logic {
        SLOT_IDLE,
        SLOT_EXEC
    } slot_state_t;

    function automatic logic [1:0] tp_phase(input logic [3:0] idx);
        return 2'(idx % 4'(SLOT_LEN));
    endfunction

endpackage

// File: rtl/wbus_xfer_sequencer_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer,
// pointer moves past the winner when the grant is taken.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   pick,
    output logic            pick_vld
);

    logic [IW-1:0] ptr;

    always_comb begin
        int unsigned k;
        k        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % 32'(NREQ);
            if (!pick_vld && req[IW'(k)]) begin
                pick_vld = 1'b1;
                pick     = IW'(k);
            end
        end
    end

    assign grant = pick_vld ? (NREQ'(1) << pick) : '0;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            ptr <= '0;
        end else if (advance && pick_vld) begin
            ptr <= (32'(pick) == NREQ - 1) ? '0 : pick + IW'(1);
        end
    end

endmodule

// File: rtl/wbus_xfer_sequencer.sv
// Timepulse ring, slot scheduling and gate decode for write-bus transfers;
// arbitration runs in phase 2 of each slot, execution in the following slot.
module wbus_xfer_sequencer
    import wbus_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int NREG = NREG_DEF,
    localparam int CW   = $clog2(NREG),
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               ena,
    input  logic               inhibit,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*CW-1:0] req_src,
    input  logic [NREQ*NREG-1:0] req_dst,
    input  logic [NREQ-1:0]    req_clr,
    output logic [NREQ-1:0]    ack,
    output logic               err,
    output logic [TP_N-1:0]    tp,
    output logic [NREG-1:0]    rg_,
    output logic [NREG-1:0]    wg_,
    output logic [NREG-1:0]    cg,
    output logic               busy,
    output logic [IW-1:0]      grant_id
);

    logic [3:0]      tp_idx;
    logic [1:0]      phase;
    slot_state_t     state, state_nxt;
    xfer_t           xfer;

    logic            arb_cycle;
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   pick;
    logic            pick_vld;

    logic [CW-1:0]   sel_src;
    logic [NREG-1:0] sel_dst;
    logic            sel_clr;
    logic            sel_err;

    assign phase     = tp_phase(tp_idx);
    assign arb_cycle = ena && !inhibit && (phase == PH_ARB);
    assign tp        = TP_N'(1) << tp_idx;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk      (clk),
        .rst_     (rst_),
        .req      (req),
        .advance  (arb_cycle),
        .grant    (grant),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    assign sel_src = req_src[pick*CW +: CW];
    assign sel_dst = req_dst[pick*NREG +: NREG];
    assign sel_clr = req_clr[pick];
    // An out-of-range source code is folded into the empty-mask error path.
    assign sel_err = (sel_dst == '0) || (32'(sel_src) >= 32'(NREG));

    assign ack = arb_cycle ? grant : '0;
    assign err = arb_cycle && pick_vld && sel_err;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tp_idx   <= '0;
            state    <= SLOT_IDLE;
            xfer     <= '0;
            grant_id <= '0;
        end else if (ena) begin
            tp_idx <= (tp_idx == 4'(TP_N - 1)) ? '0 : tp_idx + 4'd1;
            state  <= state_nxt;
            if (arb_cycle && pick_vld) begin
                xfer.src <= sel_src;
                xfer.dst <= sel_dst;
                xfer.clr <= sel_clr;
                xfer.err <= sel_err;
                grant_id <= pick;
            end
        end
    end

    // Gates decode straight from registered state, so reset releases them at once.
    always_comb begin
        state_nxt = state;
        rg_       = '1;
        wg_       = '1;
        cg        = '0;
        busy      = 1'b0;
        if (phase == PH_ARB) begin
            state_nxt = (arb_cycle && pick_vld) ? SLOT_EXEC : SLOT_IDLE;
        end
        if (state == SLOT_EXEC) begin
            busy = (phase != PH_ARB);
            if (!xfer.err) begin
                case (phase)
                    PH_CLR: begin
                        if (xfer.clr) cg = xfer.dst;
                    end
                    PH_XFER: begin
                        rg_[xfer.src] = 1'b0;
                        wg_           = ~xfer.dst;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wbus_xfer_sequencer.sv
// Directed vector bench for wbus_xfer_sequencer: per-cycle table plus
// hand-written inhibit and asynchronous-reset sequences.
module tb_wbus_xfer_sequencer;

    logic        clk = 1'b0;
    logic        rst_;
    logic        ena;
    logic        inhibit;
    logic [3:0]  req;
    logic [15:0] req_src;
    logic [63:0] req_dst;
    logic [3:0]  req_clr;
    logic [3:0]  ack;
    logic        err;
    logic [11:0] tp;
    logic [15:0] rg_;
    logic [15:0] wg_;
    logic [15:0] cg;
    logic        busy;
    logic [1:0]  grant_id;

    int ncmp = 0;
    int nerr = 0;

    typedef struct {
        logic        rst;
        logic        ena;
        logic        inh;
        logic [3:0]  req;
        logic [15:0] src;
        logic [63:0] dst;
        logic [3:0]  clr;
        int          n;
        logic [3:0]  ack;
        logic        err;
        logic [15:0] rg;
        logic [15:0] wg;
        logic [15:0] cg;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    wbus_xfer_sequencer #(.NREQ(4), .NREG(16)) dut (
        .clk      (clk),
        .rst_     (rst_),
        .ena      (ena),
        .inhibit  (inhibit),
        .req      (req),
        .req_src  (req_src),
        .req_dst  (req_dst),
        .req_clr  (req_clr),
        .ack      (ack),
        .err      (err),
        .tp       (tp),
        .rg_      (rg_),
        .wg_      (wg_),
        .cg       (cg),
        .busy     (busy),
        .grant_id (grant_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        ncmp++;
        if (act !== exp_v) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic add(input logic rst, input logic en, input logic inh, input logic [3:0] rq,
                       input logic [15:0] src, input logic [63:0] dst, input logic [3:0] clr,
                       input int n, input logic [3:0] ak, input logic er,
                       input logic [15:0] rg, input logic [15:0] wg, input logic [15:0] c,
                       input logic bz);
        vec_t v;
        v.rst = rst; v.ena = en; v.inh = inh; v.req = rq; v.src = src; v.dst = dst;
        v.clr = clr; v.n = n; v.ack = ak; v.err = er; v.rg = rg; v.wg = wg; v.cg = c;
        v.busy = bz;
        vecs.push_back(v);
    endtask

    task automatic idle(input logic rst, input int n, input logic [15:0] rg,
                        input logic [15:0] wg, input logic [15:0] c, input logic bz);
        add(rst, 1'b1, 1'b0, 4'h0, 16'h0, 64'h0, 4'h0, n, 4'h0, 1'b0, rg, wg, c, bz);
    endtask

    task automatic chk_vec(input int i);
        logic [11:0] etp;
        etp = 12'h001 << vecs[i].n;
        chk($sformatf("v%0d tp", i),   64'(tp),   64'(etp));
        chk($sformatf("v%0d ack", i),  64'(ack),  64'(vecs[i].ack));
        chk($sformatf("v%0d err", i),  64'(err),  64'(vecs[i].err));
        chk($sformatf("v%0d rg_", i),  64'(rg_),  64'(vecs[i].rg));
        chk($sformatf("v%0d wg_", i),  64'(wg_),  64'(vecs[i].wg));
        chk($sformatf("v%0d cg", i),   64'(cg),   64'(vecs[i].cg));
        chk($sformatf("v%0d busy", i), 64'(busy), 64'(vecs[i].busy));
    endtask

    initial begin
        rst_ = 1'b0; ena = 1'b0; inhibit = 1'b0; req = '0;
        req_src = '0; req_dst = '0; req_clr = '0;

        // reset and ring walk including the T12->T01 wrap
        add(1'b0, 1'b0, 1'b0, 4'h0, 16'h0, 64'h0, 4'h0, 0, 4'h0, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        for (int n = 1; n < 12; n++) idle(1'b1, n, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 1, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        // single transfer A -> Q with clear
        add(1'b1, 1'b1, 1'b0, 4'b0001, 16'h0000, 64'h0004, 4'b0001, 2, 4'b0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 3, 16'hFFFF, 16'hFFFF, 16'h0004, 1'b1);
        idle(1'b1, 4, 16'hFFFE, 16'hFFFB, 16'h0, 1'b1);
        idle(1'b1, 5, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        // synchronous-looking reset to bring the pointer back to 0
        idle(1'b0, 0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 1, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        // contention: req0 src=L dst=B, req1 src=Q dst=A, both held
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 2, 4'b0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 3, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 4, 4'b0000, 1'b0, 16'hFFFD, 16'hFEFF, 16'h0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 5, 4'b0010, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 6, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 7, 4'b0000, 1'b0, 16'hFFFB, 16'hFFFE, 16'h0, 1'b1);
        add(1'b1, 1'b1, 1'b0, 4'b0011, 16'h0021, 64'h0001_0100, 4'h0, 8, 4'b0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 9,  16'hFFFF, 16'hFFFF, 16'h0, 1'b1);
        idle(1'b1, 10, 16'hFFFD, 16'hFEFF, 16'h0, 1'b1);
        idle(1'b1, 11, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 0,  16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 1,  16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        // empty destination mask on requester 2
        add(1'b1, 1'b1, 1'b0, 4'b0100, 16'h0500, 64'h0, 4'b0100, 2, 4'b0100, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 3, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1);
        idle(1'b1, 4, 16'hFFFF, 16'hFFFF, 16'h0, 1'b1);
        idle(1'b1, 5, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 6, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 7, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        // ena=0 holds the ring at T09 and blocks the grant; source EB inside its own mask
        add(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 64'h0818, 4'b0001, 8, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 4'b0001, 16'h0003, 64'h0818, 4'b0001, 8, 4'b0000, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 4'b0001, 16'h0003, 64'h0818, 4'b0001, 8, 4'b0001, 1'b0, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);
        idle(1'b1, 9,  16'hFFFF, 16'hFFFF, 16'h0818, 1'b1);
        idle(1'b1, 10, 16'hFFF7, 16'hF7E7, 16'h0, 1'b1);
        idle(1'b1, 11, 16'hFFFF, 16'hFFFF, 16'h0, 1'b0);

        foreach (vecs[i]) begin
            @(posedge clk); #1;
            rst_ = vecs[i].rst; ena = vecs[i].ena; inhibit = vecs[i].inh; req = vecs[i].req;
            req_src = vecs[i].src; req_dst = vecs[i].dst; req_clr = vecs[i].clr;
            @(negedge clk);
            chk_vec(i);
        end

        // inhibit over a full ring with every requester asking (pointer is 1 here)
        req_src = 16'h6A97;
        req_dst = 64'h0002_0002_0040_0002;
        req_clr = 4'h0;
        for (int n = 0; n < 12; n++) begin
            logic [11:0] etp;
            etp = 12'h001 << n;
            @(posedge clk); #1;
            inhibit = 1'b1; req = 4'hF;
            @(negedge clk);
            chk($sformatf("inh%0d tp", n),  64'(tp),  64'(etp));
            chk($sformatf("inh%0d ack", n), 64'(ack), 64'h0);
            chk($sformatf("inh%0d rg_", n), 64'(rg_), 64'hFFFF);
            chk($sformatf("inh%0d wg_", n), 64'(wg_), 64'hFFFF);
            chk($sformatf("inh%0d cg", n),  64'(cg),  64'h0);
        end
        @(posedge clk); #1;
        inhibit = 1'b0;
        @(negedge clk);
        chk("uninh tp", 64'(tp), 64'h001);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("uninh tp T03", 64'(tp), 64'h004);
        chk("uninh ack", 64'(ack), 64'b0010);
        chk("uninh err", 64'(err), 64'h0);
        // inhibit raised mid-execution must not disturb the running slot
        @(posedge clk); #1;
        inhibit = 1'b1; req = 4'h0;
        @(negedge clk);
        chk("exec cg", 64'(cg), 64'h0);
        chk("exec busy", 64'(busy), 64'h1);
        chk("exec grant_id", 64'(grant_id), 64'h1);
        @(posedge clk);
        @(negedge clk);
        chk("exec rg_", 64'(rg_), 64'hFDFF);
        chk("exec wg_", 64'(wg_), 64'hFFBF);

        // asynchronous reset in the middle of the transfer phase
        #2 rst_ = 1'b0;
        #1;
        chk("arst rg_", 64'(rg_), 64'hFFFF);
        chk("arst wg_", 64'(wg_), 64'hFFFF);
        chk("arst cg", 64'(cg), 64'h0);
        chk("arst tp", 64'(tp), 64'h001);
        chk("arst busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        rst_ = 1'b1; inhibit = 1'b0; req = 4'hF;
        @(negedge clk);
        chk("post tp", 64'(tp), 64'h001);
        chk("post grant_id", 64'(grant_id), 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("post tp T03", 64'(tp), 64'h004);
        chk("post ack", 64'(ack), 64'b0001);

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end

endmodule
